// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory bus controller.
//   state_t          : controller FSM encoding (IDLE / REQ / DONE)
//   SZ_*             : ld_size codes from the LSU
//   DEFAULT_TIMEOUT  : default cycles to wait for bus_ready before faulting
//   is_misaligned()  : alignment check used when MISALIGN_TRAP_EN is defined
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int DEFAULT_TIMEOUT = 255;

    // Stores carry no size code, so their width is inferred from the
    // byte-enable pattern; loads use ld_size directly.
    function automatic logic is_misaligned(input logic       is_store,
                                           input logic [3:0] be,
                                           input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (is_store) begin
            case (be)
                4'b1111:          mis = (addr_lo != 2'b00);
                4'b0011, 4'b1100: mis = addr_lo[0];
                default:          mis = 1'b0;
            endcase
        end else begin
            case (size)
                SZ_HALF: mis = addr_lo[0];
                SZ_WORD: mis = (addr_lo != 2'b00);
                default: mis = 1'b0;
            endcase
        end
        return mis;
    endfunction

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Bus-wait timeout counter: synchronous clear has priority over enable.
// tc is high while the count equals TIMEOUT; TIMEOUT == 0 disables tc.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : clear count to zero
//   en       : increment count
//   cnt      : current count
//   tc       : terminal count reached
module dmem_timeout_ctr #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT);
    localparam logic             TO_EN  = (TIMEOUT != 0);

    logic [CNT_W-1:0] cnt_r;

    // Count register: clear, else increment while enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;
    assign tc  = TO_EN & (cnt_r == TC_VAL);

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller between the LSU and a req/ready bus.
// One bus transaction per LSU access; the pipeline is stalled from the
// access cycle until the transaction completes. Load data is returned
// right-aligned for LSU sign/zero extension.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned accesses fault
// without issuing a bus transaction).
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   data_addr, dmem_wr  : LSU byte address and store byte-enables
//   datamem_wr_o        : lane-aligned store data
//   ld_req, ld_size     : load request and size code
//   datamem_rd_in       : right-aligned load data to LSU
//   mem_stall           : hold EXE/LSU inputs stable
//   mem_fault           : one-cycle fault pulse (bus error/timeout/misalign)
//   bus_*               : req/ready bus master interface
module dmem_bus_ctrl
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_addr,
    input  logic [3:0]  dmem_wr,
    input  logic [31:0] datamem_wr_o,
    input  logic        ld_req,
    input  logic [1:0]  ld_size,
    output logic [31:0] datamem_rd_in,
    output logic        mem_stall,
    output logic        mem_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    state_t           state_r, state_s;
    logic [1:0]       addr_lo_r;
    logic             we_r;
    logic [31:0]      rdata_r;
    logic             fault_r;

    logic             access_s;
    logic             is_store_s;
    logic             misalign_s;
    logic             fault_set_s;
    logic             rd_load_s;
    logic             rd_clr_s;
    logic             cnt_clr_s;
    logic             cnt_en_s;
    logic             tc_s;
    logic [CNT_W-1:0] cnt_s;

    // Gated by rst so the stall releases immediately when reset hits.
    assign is_store_s = |dmem_wr;
    assign access_s   = ~rst & (ld_req | is_store_s);

`ifdef MISALIGN_TRAP_EN
    assign misalign_s = is_misaligned(is_store_s, dmem_wr, ld_size, data_addr[1:0]);
`else
    logic unused_s;
    assign unused_s   = ^ld_size;
    assign misalign_s = 1'b0;
`endif

    assign cnt_clr_s = (state_r != ST_REQ);
    assign cnt_en_s  = (state_r == ST_REQ);

    dmem_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout_ctr (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr_s),
        .en  (cnt_en_s),
        .cnt (cnt_s),
        .tc  (tc_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and bus/stall outputs.
    always_comb begin
        state_s     = state_r;
        fault_set_s = 1'b0;
        rd_load_s   = 1'b0;
        rd_clr_s    = 1'b0;
        mem_stall   = 1'b0;
        bus_req     = 1'b0;
        bus_we      = 1'b0;
        bus_be      = 4'b0000;
        bus_addr    = 32'h0000_0000;
        bus_wdata   = 32'h0000_0000;
        case (state_r)
            ST_IDLE: begin
                if (access_s) begin
                    mem_stall = 1'b1;
                    if (misalign_s) begin
                        state_s     = ST_DONE;
                        fault_set_s = 1'b1;
                    end else begin
                        state_s = ST_REQ;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                mem_stall = 1'b1;
                bus_req   = 1'b1;
                bus_we    = we_r;
                bus_be    = we_r ? dmem_wr : 4'b1111;
                bus_addr  = {data_addr[31:2], 2'b00};
                bus_wdata = datamem_wr_o;
                // Ready has priority over a simultaneous timeout.
                if (bus_ready) begin
                    state_s = ST_DONE;
                    if (bus_err) begin
                        fault_set_s = 1'b1;
                        rd_clr_s    = ~we_r;
                    end else begin
                        rd_load_s = ~we_r;
                    end
                end else if (tc_s) begin
                    state_s     = ST_DONE;
                    fault_set_s = 1'b1;
                    rd_clr_s    = ~we_r;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_DONE: begin
                // Same instruction still on the inputs: never re-accept here.
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Latch access attributes when an access is accepted in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_lo_r <= 2'b00;
            we_r      <= 1'b0;
        end else if ((state_r == ST_IDLE) && access_s) begin
            addr_lo_r <= data_addr[1:0];
            we_r      <= is_store_s;
        end else begin
            addr_lo_r <= addr_lo_r;
            we_r      <= we_r;
        end
    end

    // Load data register: right-align the addressed byte; stores never touch it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_r <= 32'h0000_0000;
        end else if (rd_clr_s) begin
            rdata_r <= 32'h0000_0000;
        end else if (rd_load_s) begin
            rdata_r <= bus_rdata >> {addr_lo_r, 3'b000};
        end else begin
            rdata_r <= rdata_r;
        end
    end

    // Fault flag: set on the transition into DONE, so it pulses for DONE only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_r <= 1'b0;
        end else begin
            fault_r <= fault_set_s;
        end
    end

    assign datamem_rd_in = rdata_r;
    assign mem_fault     = fault_r;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
module tb_dmem_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_addr = 32'h0;
    logic [3:0]  dmem_wr = 4'h0;
    logic [31:0] datamem_wr_o = 32'h0;
    logic        ld_req = 1'b0;
    logic [1:0]  ld_size = 2'b00;
    logic [31:0] datamem_rd_in;
    logic        mem_stall;
    logic        mem_fault;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_err = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        fault;
        logic [31:0] rdata;
        int          stall;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } cmd_t;

    rsp_t rsp_q[$];
    cmd_t cmd_q[$];

    dmem_bus_ctrl #(.TIMEOUT(8), .CNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .data_addr     (data_addr),
        .dmem_wr       (dmem_wr),
        .datamem_wr_o  (datamem_wr_o),
        .ld_req        (ld_req),
        .ld_size       (ld_size),
        .datamem_rd_in (datamem_rd_in),
        .mem_stall     (mem_stall),
        .mem_fault     (mem_fault),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_be        (bus_be),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_ready     (bus_ready),
        .bus_rdata     (bus_rdata),
        .bus_err       (bus_err)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: bus command on req rise, response on stall release.
    initial begin
        logic prev_stall;
        logic prev_req;
        int   stall_run;
        rsp_t r;
        cmd_t c;
        prev_stall = 1'b0;
        prev_req   = 1'b0;
        stall_run  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                prev_req   = 1'b0;
                stall_run  = 0;
            end else begin
                if (bus_req && !prev_req) begin
                    if (cmd_q.size() == 0) begin
                        chk("unexpected_bus_req", 32'(bus_req), 32'd0);
                    end else begin
                        c = cmd_q.pop_front();
                        chk("bus_addr", bus_addr, c.addr);
                        chk("bus_be", 32'(bus_be), 32'(c.be));
                        chk("bus_we", 32'(bus_we), 32'(c.we));
                        chk("bus_wdata", bus_wdata, c.wdata);
                    end
                end
                if (prev_stall && !mem_stall) begin
                    if (rsp_q.size() == 0) begin
                        chk("unexpected_done", 32'(mem_stall), 32'd1);
                    end else begin
                        r = rsp_q.pop_front();
                        chk("mem_fault", 32'(mem_fault), 32'(r.fault));
                        chk("datamem_rd_in", datamem_rd_in, r.rdata);
                        chk("stall_cycles", 32'(stall_run), 32'(r.stall));
                        chk("bus_req_in_done", 32'(bus_req), 32'd0);
                    end
                    stall_run = 0;
                end else begin
                    chk("fault_outside_done", 32'(mem_fault), 32'd0);
                end
                if (mem_stall) stall_run++;
                prev_stall = mem_stall;
                prev_req   = bus_req;
            end
        end
    end

    // Drive one access and act as the bus slave for it.
    task automatic txn(input logic [31:0] addr, input logic [3:0] wr, input logic [31:0] wd,
                       input logic ld, input logic [1:0] sz, input int waits,
                       input logic give_ready, input logic [31:0] rd, input logic er,
                       input logic issue, input logic [31:0] e_baddr, input logic [3:0] e_be,
                       input logic e_we, input logic e_fault, input logic [31:0] e_rd,
                       input int e_stall);
        rsp_t r;
        cmd_t c;
        int   n;
        r.fault = e_fault;
        r.rdata = e_rd;
        r.stall = e_stall;
        rsp_q.push_back(r);
        if (issue) begin
            c.addr  = e_baddr;
            c.be    = e_be;
            c.we    = e_we;
            c.wdata = wd;
            cmd_q.push_back(c);
        end
        @(posedge clk); #1;
        data_addr    = addr;
        dmem_wr      = wr;
        datamem_wr_o = wd;
        ld_req       = ld;
        ld_size      = sz;
        @(negedge clk);
        if (issue) begin
            n = 0;
            while (!bus_req && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (!bus_req) begin
                chk("bus_req_seen", 32'(bus_req), 32'd1);
            end else if (give_ready) begin
                repeat (waits) @(negedge clk);
                #1;
                bus_ready = 1'b1;
                bus_rdata = rd;
                bus_err   = er;
                @(negedge clk); #1;
                bus_ready = 1'b0;
                bus_rdata = 32'h0;
                bus_err   = 1'b0;
            end
        end
        n = 0;
        while (mem_stall && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (mem_stall) chk("done_reached", 32'(mem_stall), 32'd0);
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        dmem_wr = 4'h0;
        ld_req  = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int n;
        cmd_t c;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cmd_t c;
        int   n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_be", 32'(bus_be), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_fault", 32'(mem_fault), 32'd0);
        chk("rst_rdata", datamem_rd_in, 32'd0);
        #1 rst = 1'b0;

        //   addr          wr     wd            ld    sz     w  rdy   rdata         err  iss   baddr         be       we    flt   exp_rd        stall
        txn(32'h0000_0100, 4'h0, 32'h0,        1'b1, 2'b10, 0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0000_0100, 4'hF, 1'b0, 1'b0, 32'hDEADBEEF, 2);
        txn(32'h0000_0103, 4'h0, 32'h0,        1'b1, 2'b00, 4, 1'b1, 32'h11223344, 1'b0, 1'b1, 32'h0000_0100, 4'hF, 1'b0, 1'b0, 32'h00000011, 6);
        txn(32'h0000_0202, 4'hC, 32'hABCD0000, 1'b0, 2'b01, 1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h0000_0200, 4'hC, 1'b1, 1'b0, 32'h00000011, 3);
        txn(32'h0000_0300, 4'h0, 32'h0,        1'b1, 2'b10, 0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0300, 4'hF, 1'b0, 1'b1, 32'h00000000, 10);
        txn(32'h0000_0402, 4'h0, 32'h0,        1'b1, 2'b01, 2, 1'b1, 32'hCAFE1234, 1'b0, 1'b1, 32'h0000_0400, 4'hF, 1'b0, 1'b0, 32'h0000CAFE, 4);
        txn(32'h0000_0104, 4'h0, 32'h0,        1'b1, 2'b10, 0, 1'b1, 32'h55555555, 1'b1, 1'b1, 32'h0000_0104, 4'hF, 1'b0, 1'b1, 32'h00000000, 2);
        txn(32'h0000_0500, 4'h0, 32'h0,        1'b1, 2'b10, 0, 1'b1, 32'h12345678, 1'b0, 1'b1, 32'h0000_0500, 4'hF, 1'b0, 1'b0, 32'h12345678, 2);
        txn(32'h0000_0501, 4'h0, 32'h0,        1'b1, 2'b00, 0, 1'b1, 32'hA1B2C3D4, 1'b0, 1'b1, 32'h0000_0500, 4'hF, 1'b0, 1'b0, 32'h00A1B2C3, 2);
        // Store and load both requested: store wins, load data untouched.
        txn(32'h0000_0600, 4'h1, 32'h000000EE, 1'b1, 2'b10, 0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h0000_0600, 4'h1, 1'b1, 1'b0, 32'h00A1B2C3, 2);
        go_idle();

        // Reset in the middle of a REQ phase.
        c.addr = 32'h0000_0700; c.be = 4'hF; c.we = 1'b0; c.wdata = 32'h0;
        cmd_q.push_back(c);
        @(posedge clk); #1;
        data_addr = 32'h0000_0700; dmem_wr = 4'h0; datamem_wr_o = 32'h0; ld_req = 1'b1; ld_size = 2'b10;
        n = 0;
        @(negedge clk);
        while (!bus_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_req_before", 32'(bus_req), 32'd1);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_bus_req", 32'(bus_req), 32'd0);
        chk("midrst_stall", 32'(mem_stall), 32'd0);
        chk("midrst_fault", 32'(mem_fault), 32'd0);
        chk("midrst_rdata", datamem_rd_in, 32'd0);
        ld_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1 rst = 1'b0;

        txn(32'h0000_0800, 4'h0, 32'h0,        1'b1, 2'b10, 1, 1'b1, 32'h0BADF00D, 1'b0, 1'b1, 32'h0000_0800, 4'hF, 1'b0, 1'b0, 32'h0BADF00D, 3);
`ifdef MISALIGN_TRAP_EN
        txn(32'h0000_0101, 4'h0, 32'h0,        1'b1, 2'b10, 0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,          4'h0, 1'b0, 1'b1, 32'h0BADF00D, 1);
`endif
        go_idle();
        repeat (3) @(posedge clk);
        chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
        chk("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
